// File: rtl/tk_pkg.sv
//------------------------------------------------------------------------------
// Module   : tk_pkg
// Purpose  : Shared types and constants for the timekeeper/alarm core.
//            Holds the alarm FSM state encoding, the time-field limits,
//            the widths of the ring/snooze counters, and wrap-increment
//            helpers used by the time and alarm counters.
// Ports    : (package - none)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tk_pkg;

  // Alarm FSM state encoding
  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_t;

  // Largest legal value of each time field
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [3:0] HR_MAX  = 4'd11;

  // Upper bounds of RING_SEC / SNOOZE_SEC; the counters are sized so that
  // any legal value of either parameter fits.
  localparam int unsigned RING_SEC_LIMIT   = 255;
  localparam int unsigned SNOOZE_SEC_LIMIT = 1023;
  localparam int unsigned RING_CNT_W       = $clog2(RING_SEC_LIMIT + 1);
  localparam int unsigned SNOOZE_CNT_W     = $clog2(SNOOZE_SEC_LIMIT + 1);

  // +1 with wrap to zero past max (minutes/seconds width)
  function automatic logic [5:0] inc_wrap6(input logic [5:0] v,
                                           input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  // +1 with wrap to zero past max (hours width)
  function automatic logic [3:0] inc_wrap4(input logic [3:0] v,
                                           input logic [3:0] max);
    return (v >= max) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timekeeper_alarm_fsm.sv
//------------------------------------------------------------------------------
// Module   : alarm_fsm
// Purpose  : Alarm control FSM (OFF / ARMED / RINGING / SNOOZE) with ring
//            auto-stop timeout and snooze countdown.
// Ports    : clk, reset     - clock, async active-high reset
//            match          - alarm time reached at a minute boundary
//            tick           - 1 Hz pulse
//            snooze         - snooze request (honoured only while ringing)
//            al_toggle      - arm/disarm request (highest priority)
//            al_on          - registered: state is not OFF
//            buzzer_en      - registered: state is RINGING
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alarm_fsm
  import tk_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic match,
  input  logic tick,
  input  logic snooze,
  input  logic al_toggle,
  output logic al_on,
  output logic buzzer_en
);

  localparam logic [RING_CNT_W-1:0]   c_ring_last  = RING_CNT_W'(RING_SEC - 1);
  localparam logic [SNOOZE_CNT_W-1:0] c_snooze_ld  = SNOOZE_CNT_W'(SNOOZE_SEC);
  localparam logic [SNOOZE_CNT_W-1:0] c_snooze_one = SNOOZE_CNT_W'(1);

  alarm_state_t              r_state,      w_state_nxt;
  logic [RING_CNT_W-1:0]     r_ring_cnt,   w_ring_cnt_nxt;
  logic [SNOOZE_CNT_W-1:0]   r_snooze_cnt, w_snooze_cnt_nxt;
  logic                      r_al_on;
  logic                      r_buzzer_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_OFF;
      r_ring_cnt   <= '0;
      r_snooze_cnt <= '0;
      r_al_on      <= 1'b0;
      r_buzzer_en  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ring_cnt   <= w_ring_cnt_nxt;
      r_snooze_cnt <= w_snooze_cnt_nxt;
      // Outputs are flopped from the next state so they line up with it
      r_al_on      <= (w_state_nxt != ST_OFF);
      r_buzzer_en  <= (w_state_nxt == ST_RINGING);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ring_cnt_nxt   = r_ring_cnt;
    w_snooze_cnt_nxt = r_snooze_cnt;

    if (al_toggle) begin
      // Arm/disarm overrides every other event in the same cycle
      w_state_nxt      = (r_state == ST_OFF) ? ST_ARMED : ST_OFF;
      w_ring_cnt_nxt   = '0;
      w_snooze_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        ST_OFF: ;
        ST_ARMED: begin
          if (match) begin
            w_state_nxt    = ST_RINGING;
            w_ring_cnt_nxt = '0;
          end
        end
        ST_RINGING: begin
          // Snooze wins over a timeout landing on the same cycle
          if (snooze) begin
            w_state_nxt      = ST_SNOOZE;
            w_snooze_cnt_nxt = c_snooze_ld;
          end else if (tick) begin
            if (r_ring_cnt == c_ring_last) begin
              w_state_nxt    = ST_ARMED;
              w_ring_cnt_nxt = '0;
            end else begin
              w_ring_cnt_nxt = r_ring_cnt + 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (tick) begin
            if (r_snooze_cnt == c_snooze_one) begin
              w_state_nxt      = ST_RINGING;
              w_ring_cnt_nxt   = '0;
              w_snooze_cnt_nxt = '0;
            end else begin
              w_snooze_cnt_nxt = r_snooze_cnt - 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

  assign al_on     = r_al_on;
  assign buzzer_en = r_buzzer_en;

endmodule

`default_nettype wire

// File: rtl/timekeeper_alarm.sv
//------------------------------------------------------------------------------
// Module   : timekeeper_alarm
// Purpose  : 12-hour time-of-day counter with adjust inputs, alarm time
//            register and alarm control FSM (ring timeout + snooze).
// Ports    : clk, reset           - clock, async active-high reset
//            tick_1hz             - 1 Hz pulse
//            sec_adj/min_adj/hrs_adj - clear seconds / minutes+1 / hours+1
//            al_adj               - alarm time + AL_STEP minutes
//            al_toggle            - arm/disarm alarm
//            snooze               - snooze while ringing
//            seconds/minutes/hours - current time (registered)
//            al_minutes/al_hours  - alarm time (registered)
//            al_on, buzzer_en     - alarm status (registered)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timekeeper_alarm
  import tk_pkg::*;
#(
  parameter int unsigned AL_STEP    = 10,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       sec_adj,
  input  logic       min_adj,
  input  logic       hrs_adj,
  input  logic       al_adj,
  input  logic       al_toggle,
  input  logic       snooze,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [3:0] hours,
  output logic [5:0] al_minutes,
  output logic [3:0] al_hours,
  output logic       al_on,
  output logic       buzzer_en
);

  localparam logic [6:0] c_al_step = 7'(AL_STEP);
  localparam logic [6:0] c_sixty   = 7'd60;

  logic [5:0] r_seconds,    w_seconds_nxt;
  logic [5:0] r_minutes,    w_minutes_nxt;
  logic [3:0] r_hours,      w_hours_nxt;
  logic [5:0] r_al_minutes, w_al_minutes_nxt;
  logic [3:0] r_al_hours,   w_al_hours_nxt;
  logic       w_min_carry;
  logic       w_hr_carry;
  logic [6:0] w_al_sum;
  logic       w_al_wrap;
  logic       w_match;

  // An adjust on a field swallows the tick/carry for that field, so a
  // carry out of a field only exists when that field was not adjusted.
  assign w_min_carry = tick_1hz && (r_seconds == SEC_MAX) && !sec_adj;
  assign w_hr_carry  = w_min_carry && (r_minutes == MIN_MAX) && !min_adj;

  assign w_al_sum    = {1'b0, r_al_minutes} + c_al_step;
  assign w_al_wrap   = (w_al_sum >= c_sixty);

  always_comb begin
    w_seconds_nxt = r_seconds;
    if (sec_adj)
      w_seconds_nxt = 6'd0;
    else if (tick_1hz)
      w_seconds_nxt = inc_wrap6(r_seconds, SEC_MAX);

    w_minutes_nxt = r_minutes;
    if (min_adj || w_min_carry)
      w_minutes_nxt = inc_wrap6(r_minutes, MIN_MAX);

    w_hours_nxt = r_hours;
    if (hrs_adj || w_hr_carry)
      w_hours_nxt = inc_wrap4(r_hours, HR_MAX);

    w_al_minutes_nxt = r_al_minutes;
    w_al_hours_nxt   = r_al_hours;
    if (al_adj) begin
      w_al_minutes_nxt = w_al_wrap ? 6'(w_al_sum - c_sixty) : w_al_sum[5:0];
      if (w_al_wrap)
        w_al_hours_nxt = inc_wrap4(r_al_hours, HR_MAX);
    end
  end

  // Only a seconds rollover can match, so this fires at most once a minute;
  // compared against the post-update hours/minutes.
  assign w_match = w_min_carry &&
                   (w_minutes_nxt == r_al_minutes) &&
                   (w_hours_nxt   == r_al_hours);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seconds    <= '0;
      r_minutes    <= '0;
      r_hours      <= '0;
      r_al_minutes <= '0;
      r_al_hours   <= '0;
    end else begin
      r_seconds    <= w_seconds_nxt;
      r_minutes    <= w_minutes_nxt;
      r_hours      <= w_hours_nxt;
      r_al_minutes <= w_al_minutes_nxt;
      r_al_hours   <= w_al_hours_nxt;
    end
  end

  alarm_fsm #(
    .RING_SEC   (RING_SEC),
    .SNOOZE_SEC (SNOOZE_SEC)
  ) u_alarm_fsm (
    .clk       (clk),
    .reset     (reset),
    .match     (w_match),
    .tick      (tick_1hz),
    .snooze    (snooze),
    .al_toggle (al_toggle),
    .al_on     (al_on),
    .buzzer_en (buzzer_en)
  );

  assign seconds    = r_seconds;
  assign minutes    = r_minutes;
  assign hours      = r_hours;
  assign al_minutes = r_al_minutes;
  assign al_hours   = r_al_hours;

endmodule

`default_nettype wire

// File: tb/tb_timekeeper_alarm.sv
//------------------------------------------------------------------------------
// Module   : tb_timekeeper_alarm
// Purpose  : Self-checking bench for timekeeper_alarm. Directed scenarios
//            plus a randomized run against a behavioural model that keeps
//            the alarm time in total minutes and the alarm as "armed" plus
//            remaining ring / snooze tick budgets.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_timekeeper_alarm;

  localparam int AL_STEP    = 10;
  localparam int RING_SEC   = 6;
  localparam int SNOOZE_SEC = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0, sec_adj = 1'b0, min_adj = 1'b0, hrs_adj = 1'b0;
  logic       al_adj = 1'b0, al_toggle = 1'b0, snooze = 1'b0;
  logic [5:0] seconds, minutes, al_minutes;
  logic [3:0] hours, al_hours;
  logic       al_on, buzzer_en;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_s, m_m, m_h;      // time fields
  int m_am;               // alarm time in minutes since 0:00 (0..719)
  bit m_armed;            // alarm enabled (al_on)
  int m_ring_left;        // ticks of ringing left; >0 means buzzing
  int m_snz_left;         // ticks of snooze left; >0 means snoozing

  always #5 clk = ~clk;

  timekeeper_alarm #(
    .AL_STEP    (AL_STEP),
    .RING_SEC   (RING_SEC),
    .SNOOZE_SEC (SNOOZE_SEC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .sec_adj    (sec_adj),
    .min_adj    (min_adj),
    .hrs_adj    (hrs_adj),
    .al_adj     (al_adj),
    .al_toggle  (al_toggle),
    .snooze     (snooze),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours      (hours),
    .al_minutes (al_minutes),
    .al_hours   (al_hours),
    .al_on      (al_on),
    .buzzer_en  (buzzer_en)
  );

  task automatic model_reset();
    m_s = 0; m_m = 0; m_h = 0; m_am = 0;
    m_armed = 0; m_ring_left = 0; m_snz_left = 0;
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One clock with the given pulses; model advances with the same inputs.
  task automatic step(input bit t, input bit sa, input bit ma, input bit ha,
                      input bit aa, input bit tg, input bit sn);
    bit carry, match;
    int ns, nm, nh;
    tick_1hz = t; sec_adj = sa; min_adj = ma; hrs_adj = ha;
    al_adj = aa; al_toggle = tg; snooze = sn;

    carry = t && (m_s == 59) && !sa;
    ns = sa ? 0 : (t ? (m_s + 1) % 60 : m_s);
    nm = (ma || carry) ? (m_m + 1) % 60 : m_m;
    nh = (ha || (carry && m_m == 59 && !ma)) ? (m_h + 1) % 12 : m_h;
    match = carry && (nh * 60 + nm == m_am);

    if (tg) begin
      m_armed = !m_armed;
      m_ring_left = 0;
      m_snz_left = 0;
    end else if (m_ring_left > 0) begin
      if (sn) begin
        m_ring_left = 0;
        m_snz_left = SNOOZE_SEC;
      end else if (t) begin
        m_ring_left = m_ring_left - 1;
      end
    end else if (m_snz_left > 0) begin
      if (t) begin
        m_snz_left = m_snz_left - 1;
        if (m_snz_left == 0) m_ring_left = RING_SEC;
      end
    end else if (m_armed && match) begin
      m_ring_left = RING_SEC;
    end

    if (aa) m_am = (m_am + AL_STEP) % 720;
    m_s = ns; m_m = nm; m_h = nh;

    @(posedge clk);
    @(negedge clk);
    tick_1hz = 0; sec_adj = 0; min_adj = 0; hrs_adj = 0;
    al_adj = 0; al_toggle = 0; snooze = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Alarm 1:10 armed, time 1:09:58
  task automatic preroll();
    apply_reset();
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0, 0, 0);
    ticks(58);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if ({seconds, minutes, hours, al_minutes, al_hours, al_on, buzzer_en} !== 34'd0) begin
      failures++;
      $display("FAIL reset_state: got %h expected 0",
               {seconds, minutes, hours, al_minutes, al_hours, al_on, buzzer_en});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_time_count();
    apply_reset();
    ticks(60);
    checks++;
    if ({hours, minutes, seconds} !== {4'd0, 6'd1, 6'd0}) begin
      failures++;
      $display("FAIL count_60: got %0d:%0d:%0d expected 0:1:0", hours, minutes, seconds);
    end
    apply_reset();
    for (int i = 0; i < 11; i++) step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0, 0, 0);
    ticks(59);
    checks++;
    if ({hours, minutes, seconds} !== {4'd11, 6'd59, 6'd59}) begin
      failures++;
      $display("FAIL preset_115959: got %0d:%0d:%0d expected 11:59:59", hours, minutes, seconds);
    end
    ticks(1);
    checks++;
    if ({hours, minutes, seconds} !== 16'd0) begin
      failures++;
      $display("FAIL day_wrap: got %0d:%0d:%0d expected 0:0:0", hours, minutes, seconds);
    end
  endtask

  task automatic test_time_adjust();
    apply_reset();
    ticks(59);
    step(1, 1, 0, 0, 0, 0, 0);
    checks++;
    if ({minutes, seconds} !== {6'd0, 6'd0}) begin
      failures++;
      $display("FAIL sec_adj_vs_tick: got m=%0d s=%0d expected m=0 s=0", minutes, seconds);
    end
    for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if ({hours, minutes} !== {4'd0, 6'd0}) begin
      failures++;
      $display("FAIL min_adj_wrap: got h=%0d m=%0d expected h=0 m=0", hours, minutes);
    end
  endtask

  task automatic test_alarm_adjust();
    int exp_min;
    apply_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      exp_min = 50 + 10 * k;
      checks++;
      if ({al_hours, al_minutes} !== {4'(exp_min / 60), 6'(exp_min % 60)}) begin
        failures++;
        $display("FAIL al_adj_step%0d: got %0d:%0d expected %0d:%0d", k,
                 al_hours, al_minutes, exp_min / 60, exp_min % 60);
      end
    end
    for (int i = 0; i < 63; i++) step(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if ({al_hours, al_minutes} !== {4'd11, 6'd50}) begin
      failures++;
      $display("FAIL al_1150: got %0d:%0d expected 11:50", al_hours, al_minutes);
    end
    step(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if ({al_hours, al_minutes} !== 10'd0) begin
      failures++;
      $display("FAIL al_wrap: got %0d:%0d expected 0:0", al_hours, al_minutes);
    end
  endtask

  task automatic test_alarm_ring();
    bit bad;
    preroll();
    ticks(1);
    checks++;
    if (buzzer_en !== 1'b0 || al_on !== 1'b1) begin
      failures++;
      $display("FAIL pre_match: got buzzer=%b al_on=%b expected 0 1", buzzer_en, al_on);
    end
    ticks(1);
    checks++;
    if (buzzer_en !== 1'b1 || {hours, minutes, seconds} !== {4'd1, 6'd10, 6'd0}) begin
      failures++;
      $display("FAIL ring_start: got buzzer=%b time=%0d:%0d:%0d expected 1 at 1:10:0",
               buzzer_en, hours, minutes, seconds);
    end
    bad = 0;
    for (int i = 0; i < RING_SEC - 1; i++) begin
      ticks(1);
      if (buzzer_en !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL ring_hold: got early buzzer drop expected buzzer=1 for %0d ticks", RING_SEC - 1);
    end
    ticks(1);
    checks++;
    if (buzzer_en !== 1'b0 || al_on !== 1'b1) begin
      failures++;
      $display("FAIL auto_stop: got buzzer=%b al_on=%b expected 0 1", buzzer_en, al_on);
    end
    bad = 0;
    for (int i = 0; i < 60 - RING_SEC; i++) begin
      ticks(1);
      if (buzzer_en !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL no_rering: got buzzer=1 in minute expected 0");
    end
  endtask

  task automatic test_snooze();
    bit bad;
    preroll();
    ticks(2);
    step(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (buzzer_en !== 1'b0 || al_on !== 1'b1) begin
      failures++;
      $display("FAIL snooze_enter: got buzzer=%b al_on=%b expected 0 1", buzzer_en, al_on);
    end
    bad = 0;
    for (int i = 0; i < SNOOZE_SEC - 1; i++) begin
      ticks(1);
      if (buzzer_en !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL snooze_hold: got early re-ring expected buzzer=0");
    end
    ticks(1);
    checks++;
    if (buzzer_en !== 1'b1) begin
      failures++;
      $display("FAIL snooze_rering: got buzzer=%b expected 1", buzzer_en);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (buzzer_en !== 1'b0 || al_on !== 1'b0) begin
      failures++;
      $display("FAIL toggle_off: got buzzer=%b al_on=%b expected 0 0", buzzer_en, al_on);
    end
  endtask

  task automatic test_toggle_match();
    bit bad;
    preroll();
    ticks(1);
    step(1, 0, 0, 0, 0, 1, 0);
    bad = (buzzer_en !== 1'b0);
    for (int i = 0; i < 10; i++) begin
      ticks(1);
      if (buzzer_en !== 1'b0) bad = 1;
    end
    checks++;
    if (bad || al_on !== 1'b0) begin
      failures++;
      $display("FAIL toggle_beats_match: got buzzer_seen=%b al_on=%b expected 0 0", bad, al_on);
    end
  endtask

  task automatic test_reset_mid_ring();
    preroll();
    ticks(2);
    checks++;
    if (buzzer_en !== 1'b1) begin
      failures++;
      $display("FAIL mid_ring_setup: got buzzer=%b expected 1", buzzer_en);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({seconds, minutes, hours, al_minutes, al_hours, al_on, buzzer_en} !== 34'd0) begin
      failures++;
      $display("FAIL async_reset: got %h expected 0",
               {seconds, minutes, hours, al_minutes, al_hours, al_on, buzzer_en});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int target;
    bit t, sa, ma, ha, aa, tg, sn;
    apply_reset();
    for (int seg = 0; seg < 16; seg++) begin
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) step(0, 0, 0, 0, 1, 0, 0);
      if (!m_armed && $urandom_range(0, 3) != 0) step(0, 0, 0, 0, 0, 1, 0);
      // steer time to one minute before the alarm so rings actually occur
      target = (m_am + 719) % 720;
      while (m_h != target / 60) step(0, 0, 0, 1, 0, 0, 0);
      while (m_m != target % 60) step(0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
        t  = ($urandom_range(0, 1) == 1);
        sa = ($urandom_range(0, 99) == 0);
        ma = ($urandom_range(0, 149) == 0);
        ha = ($urandom_range(0, 199) == 0);
        aa = ($urandom_range(0, 99) == 0);
        tg = ($urandom_range(0, 119) == 0);
        sn = ($urandom_range(0, 29) == 0);
        step(t, sa, ma, ha, aa, tg, sn);
        checks++;
        if ({seconds, minutes, hours, al_minutes, al_hours, al_on, buzzer_en} !==
            {6'(m_s), 6'(m_m), 4'(m_h), 6'(m_am % 60), 4'(m_am / 60), m_armed,
             (m_ring_left > 0)}) begin
          failures++;
          $display("FAIL random_seg%0d_cyc%0d: got %0d:%0d:%0d al=%0d:%0d on=%b bz=%b expected %0d:%0d:%0d al=%0d:%0d on=%b bz=%b",
                   seg, i, hours, minutes, seconds, al_hours, al_minutes, al_on, buzzer_en,
                   m_h, m_m, m_s, m_am / 60, m_am % 60, m_armed, (m_ring_left > 0));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_time_count();
    test_time_adjust();
    test_alarm_adjust();
    test_alarm_ring();
    test_snooze();
    test_toggle_match();
    test_reset_mid_ring();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
